// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address/line field helpers for the
// direct-mapped read-only cache controller.
package cache_pkg;

  localparam int ADDR_W = 15;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 10;
  localparam int OFF_W  = 2;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  function automatic logic [ADDR_W-OFF_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFF_W];
  endfunction

  // Offset k selects bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    return line[WORD_W*int'(off) +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag store for the direct-mapped cache: registered read port and a
// single write port; valid bits are cleared by the synchronous reset.
module cache_tag_store #(
  parameter int LINES = 1024,
  parameter int TAG_W = 3,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic             rd_valid_q;
  logic [TAG_W-1:0] rd_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: the tag array is deliberately not reset; a cleared valid bit makes
  // any stale tag irrelevant, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
    end else begin
      rd_valid_q <= valid_q[rd_index];
      rd_tag_q   <= tag_q[rd_index];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;

endmodule

// File: rtl/cache_controller.sv
// Sequencing controller for the direct-mapped read-only cache: hit/miss
// decision, line fill from main memory, response hold and hit/miss counters.
module cache_controller #(
  parameter int ADDR_W = 15,
  parameter int LINES  = 1024,
  parameter int TAG_W  = 3,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  input  logic [ADDR_W-1:0]                    req_addr,
  output logic                                 req_ready,
  output logic                                 resp_valid,
  output logic [WORD_W-1:0]                    resp_data,
  output logic                                 resp_hit,
  input  logic                                 resp_ready,
  output logic                                 mem_rd,
  output logic [ADDR_W-cache_pkg::OFF_W-1:0]   mem_addr,
  input  logic                                 mem_ack,
  input  logic [LINE_W-1:0]                    mem_data,
  output logic [cache_pkg::IDX_W-1:0]          arr_index,
  output logic                                 arr_we,
  output logic [LINE_W-1:0]                    arr_wdata,
  input  logic [LINE_W-1:0]                    arr_rdata,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
);

  import cache_pkg::state_e, cache_pkg::IDLE, cache_pkg::LOOKUP;
  import cache_pkg::FILL, cache_pkg::RESP;
  import cache_pkg::tag_of, cache_pkg::index_of, cache_pkg::off_of;
  import cache_pkg::line_of, cache_pkg::word_sel;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_hit_q, resp_hit_d;
  logic [31:0]         hit_q, hit_d;
  logic [31:0]         miss_q, miss_d;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic                tag_we;

  cache_tag_store #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (cache_pkg::IDX_W)
  ) u_tag_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (arr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .we       (tag_we),
    .wr_index (index_of(addr_q)),
    .wr_tag   (tag_of(addr_q))
  );

  // NOTE: every output and _d signal gets a default before the case so no
  // path through this block leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    resp_data_d = resp_data_q;
    resp_hit_d  = resp_hit_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    req_ready   = 1'b0;
    mem_rd      = 1'b0;
    arr_we      = 1'b0;
    tag_we      = 1'b0;
    arr_index   = index_of(addr_q);

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        arr_index = index_of(req_addr);
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rd_valid && (rd_tag == tag_of(addr_q))) begin
          hit_d       = hit_q + 32'd1;
          resp_data_d = word_sel(arr_rdata, off_of(addr_q));
          resp_hit_d  = 1'b1;
          state_d     = RESP;
        end else begin
          miss_d  = miss_q + 32'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          // A reset in this same cycle must not leave a half-installed line.
          arr_we      = !rst;
          tag_we      = !rst;
          resp_data_d = word_sel(mem_data, off_of(addr_q));
          resp_hit_d  = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      resp_data_q <= resp_data_d;
      resp_hit_q  <= resp_hit_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign mem_addr   = line_of(addr_q);
  assign arr_wdata  = mem_data;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: main-memory and data-array models,
// a tag-store reference model and a response scoreboard queue.
module tb_cache_controller;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [14:0]  req_addr = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_hit;
  logic         resp_ready = 1'b0;
  logic         mem_rd;
  logic [12:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [127:0] mem_data = '0;
  logic [9:0]   arr_index;
  logic         arr_we;
  logic [127:0] arr_wdata;
  logic [127:0] arr_rdata = '0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int           checks = 0;
  int           failures = 0;
  logic [31:0]  exp_hits = '0;
  logic [31:0]  exp_misses = '0;
  bit           tb_valid [1024];
  logic [2:0]   tb_tag [1024];
  logic [127:0] darr [1024];
  exp_t         sb_q [$];

  cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_hit   (resp_hit),
    .resp_ready (resp_ready),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .arr_index  (arr_index),
    .arr_we     (arr_we),
    .arr_wdata  (arr_wdata),
    .arr_rdata  (arr_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Data array: one-cycle synchronous read, line write on arr_we.
  always @(posedge clk) begin
    if (arr_we) darr[arr_index] <= arr_wdata;
    arr_rdata <= darr[arr_index];
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Main-memory contents: word k of line a = 0x10000000*(k+1) ^ a, except
  // word1 of line 1 which is 0xDEADBEEF.
  function automatic logic [127:0] mem_line(input logic [12:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (32'h1000_0000 * 32'(k + 1)) ^ {19'b0, a};
    if (a == 13'h0001) l[63:32] = 32'hDEADBEEF;
    return l;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) tb_valid[i] = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    sb_q.delete();
  endtask

  task automatic do_read(input logic [14:0] addr, input int ack_delay,
                         input int hold, input bit stray_req);
    logic [127:0] line;
    logic [31:0]  w;
    logic [9:0]   idx;
    logic [2:0]   tag;
    bit           hit;
    exp_t         e;
    idx  = addr[11:2];
    tag  = addr[14:12];
    hit  = tb_valid[idx] && (tb_tag[idx] == tag);
    line = mem_line(addr[14:2]);
    w    = line[32*int'(addr[1:0]) +: 32];
    e    = '0;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready_idle addr=%h got=%b exp=1", addr, req_ready); end
    req_valid = 1'b1;
    req_addr  = addr;
    sb_q.push_back('{data: w, hit: hit});
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      tb_valid[idx] = 1'b1;
      tb_tag[idx]   = tag;
    end

    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, mem_rd, req_ready} !== 3'b000) begin
      failures++; $display("FAIL lookup_outputs addr=%h got rv/rd/rr=%b exp=000", addr, {resp_valid, mem_rd, req_ready});
    end

    @(negedge clk);
    if (!hit) begin
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== addr[14:2] || resp_valid !== 1'b0) begin
        failures++; $display("FAIL fill_start addr=%h got mem_rd=%b mem_addr=%h rv=%b exp 1/%h/0", addr, mem_rd, mem_addr, resp_valid, addr[14:2]);
      end
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== addr[14:2] || arr_we !== 1'b0 || resp_valid !== 1'b0) begin
          failures++; $display("FAIL fill_wait addr=%h got mem_rd=%b mem_addr=%h we=%b rv=%b", addr, mem_rd, mem_addr, arr_we, resp_valid);
        end
      end
      mem_ack  = 1'b1;
      mem_data = line;
      #1;
      checks++;
      if (arr_we !== 1'b1 || arr_index !== idx || arr_wdata !== line) begin
        failures++; $display("FAIL fill_write addr=%h got we=%b idx=%h exp we=1 idx=%h", addr, arr_we, arr_index, idx);
      end
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_data = {4{32'h5A5A_A5A5}};
      checks++;
      if (arr_we !== 1'b0 || mem_rd !== 1'b0) begin
        failures++; $display("FAIL fill_done addr=%h got we=%b mem_rd=%b exp 0/0", addr, arr_we, mem_rd);
      end
    end else begin
      checks++;
      if (mem_rd !== 1'b0) begin failures++; $display("FAIL hit_no_mem_rd addr=%h got=%b exp=0", addr, mem_rd); end
    end

    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL resp_latency addr=%h got=%b exp=1", addr, resp_valid); end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL scoreboard_empty addr=%h got=0 entries exp>=1", addr);
    end else begin
      e = sb_q.pop_front();
      if (resp_data !== e.data || resp_hit !== e.hit) begin
        failures++; $display("FAIL resp_data addr=%h got=%h/%b exp=%h/%b", addr, resp_data, resp_hit, e.data, e.hit);
      end
    end

    for (int i = 0; i < hold; i++) begin
      if (stray_req && i == 1) begin req_valid = 1'b1; req_addr = 15'h0006; end
      else req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e.data || resp_hit !== e.hit || req_ready !== 1'b0) begin
        failures++; $display("FAIL resp_hold addr=%h cyc=%0d got rv=%b data=%h hit=%b rr=%b exp 1/%h/%b/0", addr, i, resp_valid, resp_data, resp_hit, req_ready, e.data, e.hit);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL resp_release addr=%h got rv=%b rr=%b exp 0/1", addr, resp_valid, req_ready);
    end
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      failures++; $display("FAIL counters addr=%h got hit=%0d miss=%0d exp hit=%0d miss=%0d", addr, hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_hit !== 1'b0 ||
        mem_rd !== 1'b0 || arr_we !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      failures++; $display("FAIL reset_state got rr=%b rv=%b data=%h hit=%b rd=%b we=%b hc=%0d mc=%0d", req_ready, resp_valid, resp_data, resp_hit, mem_rd, arr_we, hit_count, miss_count);
    end
  endtask

  task automatic test_cold_miss();
    do_read(15'h0005, 3, 0, 1'b0);
  endtask

  task automatic test_hit();
    do_read(15'h0006, 0, 0, 1'b0);
  endtask

  task automatic test_conflict();
    do_read(15'h1005, 1, 0, 1'b0);
    do_read(15'h0005, 0, 0, 1'b0);
  endtask

  task automatic test_resp_hold();
    do_read(15'h0007, 0, 5, 1'b1);
  endtask

  task automatic test_reset_in_fill();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 15'h0009;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1) begin failures++; $display("FAIL rst_fill_entry got mem_rd=%b exp=1", mem_rd); end
    rst      = 1'b1;
    mem_ack  = 1'b1;
    mem_data = mem_line(13'h0002);
    #1;
    checks++;
    if (arr_we !== 1'b0) begin failures++; $display("FAIL rst_no_write got arr_we=%b exp=0", arr_we); end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || resp_valid !== 1'b0 || arr_we !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      failures++; $display("FAIL rst_fill_drop got rd=%b rv=%b we=%b hc=%0d mc=%0d exp 0/0/0/0/0", mem_rd, resp_valid, arr_we, hit_count, miss_count);
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_fill_ready got=%b exp=1", req_ready); end
    do_read(15'h0005, 2, 0, 1'b0);
  endtask

  task automatic test_fast_ack();
    do_read(15'h0009, 0, 0, 1'b0);
    @(negedge clk);
    mem_ack  = 1'b1;
    mem_data = {4{32'hFFFF_0000}};
    #1;
    checks++;
    if (arr_we !== 1'b0) begin failures++; $display("FAIL stray_ack_we got=%b exp=0", arr_we); end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        hit_count !== exp_hits || miss_count !== exp_misses) begin
      failures++; $display("FAIL stray_ack_idle got rd=%b rv=%b rr=%b hc=%0d mc=%0d", mem_rd, resp_valid, req_ready, hit_count, miss_count);
    end
    do_read(15'h000A, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [14:0] addrs [8];
    addrs = '{15'h0004, 15'h2004, 15'h0004, 15'h7FFF, 15'h7FFC, 15'h3001, 15'h2006, 15'h7FFD};
    for (int i = 0; i < 8; i++) begin
      do_read(addrs[i], int'($urandom_range(0, 2)), 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_resp_hold();
    test_reset_in_fill();
    test_fast_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
